// File: rtl/dff_pkg.sv
// dff_pkg: shared width limit, reset-value type and width check for d_flip_flop
package dff_pkg;
  localparam int DFF_MAX_WIDTH = 1024;
  typedef logic [DFF_MAX_WIDTH-1:0] default_rst_t;
  function automatic bit dff_width_ok(input int width);
    return width >= 1 && width <= DFF_MAX_WIDTH;
  endfunction
endpackage

// File: rtl/d_flip_flop.sv
// d_flip_flop: WIDTH-bit D register with sync reset to RST_VAL and complement output
// DFF_CHANGE_FLAG_EN adds a registered one-cycle "changed" flag
module d_flip_flop
  import dff_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter default_rst_t RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
`ifdef DFF_CHANGE_FLAG_EN
  ,
  output logic             changed
`endif
);
  if (!dff_width_ok(WIDTH)) begin : g_bad_width
    $error("d_flip_flop: WIDTH %0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
  end
  // if() rather than a ternary so an X/Z rst falls through to normal capture
  always_ff @(posedge clk)
    if (rst) Q <= RST_VAL[WIDTH-1:0];
    else Q <= D;
  assign Qn = ~Q;
`ifdef DFF_CHANGE_FLAG_EN
  always_ff @(posedge clk)
    if (rst) changed <= 1'b0;
    else changed <= D != Q;
`endif
endmodule

// File: tb/tb_d_flip_flop.sv
// tb_d_flip_flop: directed checks of d_flip_flop at widths 1, 8 and 32 (and 4 with the change flag)
module tb_d_flip_flop;
  logic clk = 1'b0;
  logic d1;
  logic [7:0] d8;
  logic r8;
  logic [31:0] d32;
  logic r32;
  logic q1, qn1;
  logic [7:0] q8, qn8;
  logic [31:0] q32, qn32;
  logic m1, v = 1'b0;
  logic [7:0] m8;
  logic [31:0] m32;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  d_flip_flop #(.WIDTH(1)) u1 (
    .clk(clk), .rst(1'b0), .D(d1), .Q(q1), .Qn(qn1)
`ifdef DFF_CHANGE_FLAG_EN
    , .changed()
`endif
  );
  d_flip_flop #(.WIDTH(8), .RST_VAL('hA5)) u8 (
    .clk(clk), .rst(r8), .D(d8), .Q(q8), .Qn(qn8)
`ifdef DFF_CHANGE_FLAG_EN
    , .changed()
`endif
  );
  d_flip_flop #(.WIDTH(32)) u32 (
    .clk(clk), .rst(r32), .D(d32), .Q(q32), .Qn(qn32)
`ifdef DFF_CHANGE_FLAG_EN
    , .changed()
`endif
  );

`ifdef DFF_CHANGE_FLAG_EN
  logic [3:0] d4, q4, qn4, m4;
  logic r4, chg4, mchg4;
  d_flip_flop #(.WIDTH(4)) u4 (
    .clk(clk), .rst(r4), .D(d4), .Q(q4), .Qn(qn4), .changed(chg4)
  );
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each output is whatever the rules say the previous rising edge sampled
  always @(posedge clk) begin
    m1  <= d1;
    m8  <= r8 ? 8'hA5 : d8;
    m32 <= r32 ? 32'h0 : d32;
    v   <= 1'b1;
`ifdef DFF_CHANGE_FLAG_EN
    mchg4 <= !r4 && (d4 != m4);
    m4    <= r4 ? 4'h0 : d4;
`endif
  end

  always @(negedge clk)
    if (v) begin
      check("q1", {31'b0, q1}, {31'b0, m1});
      check("qn1", {31'b0, qn1}, {31'b0, ~m1});
      check("q8", {24'b0, q8}, {24'b0, m8});
      check("qn8", {24'b0, qn8}, {24'b0, ~m8});
      check("q32", q32, m32);
      check("qn32", qn32, {~m32});
`ifdef DFF_CHANGE_FLAG_EN
      check("q4", {28'b0, q4}, {28'b0, m4});
      check("chg4", {31'b0, chg4}, {31'b0, mchg4});
`endif
    end

  initial begin
    d1 = 1'b0; d8 = 8'h3C; r8 = 1'b1; d32 = '0; r32 = 1'b1;
`ifdef DFF_CHANGE_FLAG_EN
    d4 = 4'h0; r4 = 1'b1;
`endif
    @(posedge clk); #1;
    check("rst_q8", {24'b0, q8}, 32'hA5);
    check("rst_qn8", {24'b0, qn8}, 32'h5A);
    check("rst_q32", q32, 32'h0);
    check("cap0_q1", {31'b0, q1}, 32'h0);
    // basic capture on the 1-bit instance
    d1 = 1'b1;
    @(posedge clk); #1;
    check("cap1_q1", {31'b0, q1}, 32'h1);
    check("cap1_qn1", {31'b0, qn1}, 32'h0);
    @(negedge clk); #1;
    check("fall_q1", {31'b0, q1}, 32'h1);
    d1 = 1'b0; #2;
    check("dchg_q1", {31'b0, q1}, 32'h1);
    @(posedge clk); #1;
    check("cap2_q1", {31'b0, q1}, 32'h0);
    check("cap2_qn1", {31'b0, qn1}, 32'h1);
    // D toggles while clk low must not reach Q
    @(negedge clk); #1;
    d1 = 1'b1; #1 d1 = 1'b0; #1 d1 = 1'b1; #1;
    check("hold_q1", {31'b0, q1}, 32'h0);
    // reset release: first capture is on the first edge sampling rst=0
    r8 = 1'b0; d8 = 8'hFF;
    @(posedge clk); #1;
    check("rel_q8", {24'b0, q8}, 32'hFF);
    check("tog_q1", {31'b0, q1}, 32'h1);
    r8 = 1'b1; #2;
    check("rstmid_q8", {24'b0, q8}, 32'hFF);
    @(posedge clk); #1;
    check("rstedge_q8", {24'b0, q8}, 32'hA5);
    check("rstedge_qn8", {24'b0, qn8}, 32'h5A);
    r8 = 1'b0; d8 = 8'h3C;
    @(posedge clk); #1;
    check("after_q8", {24'b0, q8}, 32'h3C);
    // random sweep on the 32-bit instance, checked every cycle by the model
    r32 = 1'b0;
    for (int i = 0; i < 100; i++) begin
      d32 = $urandom;
      @(posedge clk); #1;
      check("sweep_q32", q32, d32);
    end
`ifdef DFF_CHANGE_FLAG_EN
    r4 = 1'b0; d4 = 4'h3;
    @(posedge clk); #1;
    check("chg_first", {31'b0, chg4}, 32'h1);
    @(posedge clk); #1;
    check("chg_same", {31'b0, chg4}, 32'h0);
    d4 = 4'h7;
    @(posedge clk); #1;
    check("chg_new", {31'b0, chg4}, 32'h1);
    @(posedge clk); #1;
    check("chg_pulse", {31'b0, chg4}, 32'h0);
    r4 = 1'b1; d4 = 4'h9;
    @(posedge clk); #1;
    check("chg_rst", {31'b0, chg4}, 32'h0);
    check("chg_rst_q", {28'b0, q4}, 32'h0);
`endif
    @(negedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
